alu_muldiv: RTL and testbench
=============================

// Module: alu_muldiv
// PURPOSE
//  Width-parametrised execute-stage ALU with an integrated iterative multiply/divide unit and HI/LO registers.
//  The combinational ALU path is single-cycle, with a signed-overflow flag added.
//  MULT/MULTU/DIV/DIVU run as multi-cycle radix-2 operations under a start/busy/done handshake.
//  MFHI/MFLO/MTHI/MTLO access HI/LO. The pipeline control stalls the execute stage while busy=1.
// PARAMETERS
//  WIDTH    32               datapath width; must be a power of 2, >= 8
//  SHAMT_W  $clog2(WIDTH)    shift-amount width
// PORTS
//  clk       in   1      clock; all state updates on the rising edge
//  reset     in   1      asynchronous, active-high reset
//  opA       in   WIDTH  operand A (rs, or sa for immediate shifts)
//  opB       in   WIDTH  operand B (rt or immediate)
//  aluFunct  in   6      function code, ISA.v FUN_* encoding
//  start     in   1      issue strobe for MULT/MULTU/DIV/DIVU/MTHI/MTLO
//  out       out  WIDTH  combinational result
//  zero      out  1      out == 0
//  overflow  out  1      signed overflow of FUN_ADD/FUN_SUB; 0 for every other funct
//  busy      out  1      multiply/divide in progress
//  done      out  1      one-cycle pulse: HI/LO were just written by a mult/div
//  hi, lo    out  WIDTH  HI and LO registers, always visible
// BEHAVIOUR
//  Reset (async, any state): FSM=IDLE, hi=lo=0, busy=0, done=0, iteration counter=0, operand/shadow regs=0.
//  Combinational functs: same set as the base ALU, with these width rules.
//   - Every shift amount is opA[SHAMT_W-1:0], including SLL/SRL/SRA.
//   - LUI gives opB << (WIDTH/2).
//   - SLT/SLTU/SLE give 1 or 0, zero-extended.
//   - overflow = (sign(A)==sign(B')) && (sign(out)!=sign(A)), with B' = opB for ADD and ~opB for SUB.
//   - MFHI gives hi, MFLO gives lo; while busy they return the pre-operation values.
//   - Unrecognised funct gives out=0. JR/JALR/NO give out=0 (no X propagation).
//  FSM states: IDLE, RUN, DONE.
//   - IDLE/DONE + start + MULT*/DIV*: latch operands, counter=0 -> RUN. Start is also accepted in DONE (back-to-back).
//   - RUN: one iteration per cycle. Counter increments; when counter==WIDTH-1 the edge writes hi/lo -> DONE.
//   - DONE: done=1 for exactly one cycle -> IDLE (or -> RUN if a new start arrives).
//   - busy=1 exactly in RUN. Latency is start edge to hi/lo valid = WIDTH+1 edges. done is high in the cycle after the write.
//   - start while busy is ignored. No queueing; the issuing stage must hold.
//   - start with MTHI or MTLO while not busy: hi (or lo) <= opA at that edge. FSM unchanged, no done pulse.
//   - start with MTHI or MTLO while busy: ignored.
//   - start with any other funct: ignored.
//  Multiply: shift-add on magnitudes, 2*WIDTH product. MULT negates the product if the operand signs differ.
//   Result: {hi,lo} = product.
//  Divide: restoring division on magnitudes. lo = quotient, hi = remainder.
//   Signed: quotient is negative if the signs differ; remainder takes the sign of the dividend.
//   Divide by zero: lo = all ones, hi = opA (dividend as given). Still takes WIDTH cycles.
//   DIV of MIN by -1: lo = MIN, hi = 0 (truncated result).
//  Operands are latched at start; changes to opA/opB during RUN have no effect.
//  Reset asserted during RUN aborts the operation: hi=lo=0, no done pulse.
// TESTING (WIDTH=32 unless noted)
//  1. ADD 7FFFFFFF+1 -> out=80000000, overflow=1. ADDU same operands -> overflow=0.
//     SUB 80000000-1 -> overflow=1. SRA opB=80000000, opA=0x24 -> shamt 4, out=F8000000.
//  2. MULT FFFFFFFF*FFFFFFFF -> hi=0, lo=1. MULTU same -> hi=FFFFFFFE, lo=00000001.
//     Check busy=1 for 32 cycles, done pulses once, hi/lo valid on cycle 33.
//  3. DIV -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF. DIVU 7/0 -> lo=FFFFFFFF, hi=7.
//     DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
//  4. MULT issued in the DONE cycle of a prior DIV: accepted without an idle cycle.
//     start asserted during RUN (including MTHI): hi/lo unaffected. MFLO during RUN returns the old lo.
//  5. Assert reset at RUN iteration 10: busy=0 and hi=lo=0 immediately (async), no done.
//     Release reset, then MTLO 1234 -> lo=1234.
//  6. WIDTH=8: MULTU FF*FF -> hi=FE, lo=01 after 8 RUN cycles. Random compare vs. reference model, 10k ops.

Source files
------------

// File: rtl/alu_muldiv.sv
// Execute-stage ALU with single-cycle combinational path and an iterative
// radix-2 multiply/divide unit that owns the HI/LO registers.
module alu_muldiv #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [5:0]       aluFunct,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] FUN_SLL   = 6'h00;
  localparam logic [5:0] FUN_SRL   = 6'h02;
  localparam logic [5:0] FUN_SRA   = 6'h03;
  localparam logic [5:0] FUN_SLLV  = 6'h04;
  localparam logic [5:0] FUN_SRLV  = 6'h06;
  localparam logic [5:0] FUN_SRAV  = 6'h07;
  localparam logic [5:0] FUN_JR    = 6'h08;
  localparam logic [5:0] FUN_JALR  = 6'h09;
  localparam logic [5:0] FUN_LUI   = 6'h0F;
  localparam logic [5:0] FUN_MFHI  = 6'h10;
  localparam logic [5:0] FUN_MTHI  = 6'h11;
  localparam logic [5:0] FUN_MFLO  = 6'h12;
  localparam logic [5:0] FUN_MTLO  = 6'h13;
  localparam logic [5:0] FUN_MULT  = 6'h18;
  localparam logic [5:0] FUN_MULTU = 6'h19;
  localparam logic [5:0] FUN_DIV   = 6'h1A;
  localparam logic [5:0] FUN_DIVU  = 6'h1B;
  localparam logic [5:0] FUN_ADD   = 6'h20;
  localparam logic [5:0] FUN_ADDU  = 6'h21;
  localparam logic [5:0] FUN_SUB   = 6'h22;
  localparam logic [5:0] FUN_SUBU  = 6'h23;
  localparam logic [5:0] FUN_AND   = 6'h24;
  localparam logic [5:0] FUN_OR    = 6'h25;
  localparam logic [5:0] FUN_XOR   = 6'h26;
  localparam logic [5:0] FUN_NOR   = 6'h27;
  localparam logic [5:0] FUN_SLT   = 6'h2A;
  localparam logic [5:0] FUN_SLTU  = 6'h2B;
  localparam logic [5:0] FUN_SLE   = 6'h2C;
  localparam logic [5:0] FUN_NO    = 6'h3F;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0]   acc, wlo, dvs, op_a_q;
  logic               is_div, neg_res, neg_rem, div0;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   add_res, sub_res;
  logic               md_go, mthi_go, mtlo_go, last, op_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0]   acc_n, lo_n, hi_res, lo_res;
  logic [2*WIDTH-1:0] prod;

  assign shamt   = opA[SHAMT_W-1:0];
  assign add_res = opA + opB;
  assign sub_res = opA - opB;

  // Single-cycle ALU path
  always_comb begin
    out      = '0;
    overflow = 1'b0;
    case (aluFunct)
      FUN_ADD: begin
        out      = add_res;
        overflow = (opA[WIDTH-1] == opB[WIDTH-1]) && (add_res[WIDTH-1] != opA[WIDTH-1]);
      end
      FUN_SUB: begin
        out      = sub_res;
        overflow = (opA[WIDTH-1] != opB[WIDTH-1]) && (sub_res[WIDTH-1] != opA[WIDTH-1]);
      end
      FUN_ADDU:                  out = add_res;
      FUN_SUBU:                  out = sub_res;
      FUN_AND:                   out = opA & opB;
      FUN_OR:                    out = opA | opB;
      FUN_XOR:                   out = opA ^ opB;
      FUN_NOR:                   out = ~(opA | opB);
      FUN_SLT:                   out = WIDTH'($signed(opA) < $signed(opB));
      FUN_SLTU:                  out = WIDTH'(opA < opB);
      FUN_SLE:                   out = WIDTH'($signed(opA) <= $signed(opB));
      FUN_SLL, FUN_SLLV:         out = opB << shamt;
      FUN_SRL, FUN_SRLV:         out = opB >> shamt;
      FUN_SRA, FUN_SRAV:         out = WIDTH'($signed(opB) >>> shamt);
      FUN_LUI:                   out = opB << (WIDTH / 2);
      FUN_MFHI:                  out = hi;
      FUN_MFLO:                  out = lo;
      FUN_JR, FUN_JALR, FUN_NO:  out = '0;
      default:                   out = '0;
    endcase
  end

  assign zero = (out == '0);

  assign md_go   = start && (state_q != S_RUN) &&
                   (aluFunct inside {FUN_MULT, FUN_MULTU, FUN_DIV, FUN_DIVU});
  assign mthi_go = start && (state_q != S_RUN) && (aluFunct == FUN_MTHI);
  assign mtlo_go = start && (state_q != S_RUN) && (aluFunct == FUN_MTLO);
  assign last    = (cnt == SHAMT_W'(WIDTH - 1));
  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);

  assign op_signed = (aluFunct == FUN_MULT) || (aluFunct == FUN_DIV);
  assign a_neg     = op_signed && opA[WIDTH-1];
  assign b_neg     = op_signed && opB[WIDTH-1];
  assign a_mag     = a_neg ? -opA : opA;
  assign b_mag     = b_neg ? -opB : opB;

  // One shift-add or restore-subtract step; the partial remainder always stays below 2*dvs
  always_comb begin
    mul_sum   = {1'b0, acc} + (wlo[0] ? {1'b0, dvs} : '0);
    div_shift = {acc, wlo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, dvs};
    if (is_div) begin
      acc_n = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      lo_n  = {wlo[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      acc_n = mul_sum[WIDTH:1];
      lo_n  = {mul_sum[0], wlo[WIDTH-1:1]};
    end
  end

  // Sign fix-up and divide-by-zero override applied on the final edge
  always_comb begin
    prod = {acc_n, lo_n};
    if (neg_res) prod = -prod;
    if (!is_div) begin
      hi_res = prod[2*WIDTH-1:WIDTH];
      lo_res = prod[WIDTH-1:0];
    end else if (div0) begin
      hi_res = op_a_q;
      lo_res = '1;
    end else begin
      hi_res = neg_rem ? -acc_n : acc_n;
      lo_res = neg_res ? -lo_n : lo_n;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (md_go) state_d = S_RUN;
      S_RUN:   if (last) state_d = S_DONE;
      S_DONE:  state_d = md_go ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Operand shadows and iteration registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      acc     <= '0;
      wlo     <= '0;
      dvs     <= '0;
      op_a_q  <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
    end else if (md_go) begin
      cnt     <= '0;
      acc     <= '0;
      wlo     <= a_mag;
      dvs     <= b_mag;
      op_a_q  <= opA;
      is_div  <= (aluFunct == FUN_DIV) || (aluFunct == FUN_DIVU);
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
      div0    <= (opB == '0);
    end else if (state_q == S_RUN) begin
      cnt <= cnt + SHAMT_W'(1);
      acc <= acc_n;
      wlo <= lo_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if ((state_q == S_RUN) && last) begin
      hi <= hi_res;
      lo <= lo_res;
    end else begin
      if (mthi_go) hi <= opA;
      if (mtlo_go) lo <= opA;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv (WIDTH=32): directed ALU/mult/div cases,
// handshake corner cases, async reset abort and a random sweep.
module tb_alu_muldiv;

  localparam int unsigned W = 32;

  localparam logic [5:0] FUN_SLL   = 6'h00;
  localparam logic [5:0] FUN_SRLV  = 6'h06;
  localparam logic [5:0] FUN_SRA   = 6'h03;
  localparam logic [5:0] FUN_JR    = 6'h08;
  localparam logic [5:0] FUN_LUI   = 6'h0F;
  localparam logic [5:0] FUN_MFHI  = 6'h10;
  localparam logic [5:0] FUN_MTHI  = 6'h11;
  localparam logic [5:0] FUN_MFLO  = 6'h12;
  localparam logic [5:0] FUN_MTLO  = 6'h13;
  localparam logic [5:0] FUN_MULT  = 6'h18;
  localparam logic [5:0] FUN_MULTU = 6'h19;
  localparam logic [5:0] FUN_DIV   = 6'h1A;
  localparam logic [5:0] FUN_DIVU  = 6'h1B;
  localparam logic [5:0] FUN_ADD   = 6'h20;
  localparam logic [5:0] FUN_ADDU  = 6'h21;
  localparam logic [5:0] FUN_SUB   = 6'h22;
  localparam logic [5:0] FUN_SUBU  = 6'h23;
  localparam logic [5:0] FUN_NOR   = 6'h27;
  localparam logic [5:0] FUN_SLT   = 6'h2A;
  localparam logic [5:0] FUN_SLTU  = 6'h2B;
  localparam logic [5:0] FUN_SLE   = 6'h2C;
  localparam logic [5:0] FUN_NO    = 6'h3F;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] opA, opB;
  logic [5:0]   aluFunct;
  logic         start;
  logic [W-1:0] out, hi, lo;
  logic         zero, overflow, busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sb[$];

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .opA(opA), .opB(opB), .aluFunct(aluFunct),
    .start(start), .out(out), .zero(zero), .overflow(overflow),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] md_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    int q, r;
    case (f)
      FUN_MULT: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return p;
      end
      FUN_MULTU: return {32'd0, a} * {32'd0, b};
      FUN_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      FUN_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Scoreboard pop on every done pulse
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) check_eq("done_with_empty_sb", 64'(sb.size()), 64'd1);
      else check_eq("hilo", {hi, lo}, sb.pop_front());
    end
  end

  task automatic drive_start(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    opA = a; opB = b; aluFunct = f; start = 1'b1;
    @(negedge clk);
    start = 1'b0; aluFunct = FUN_NO;
  endtask

  task automatic issue_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    sb.push_back(md_model(f, a, b));
    drive_start(f, a, b);
  endtask

  task automatic wait_done(output int nb);
    nb = 0;
    for (int i = 0; i < 200; i++) begin
      if (done) break;
      if (busy) nb++;
      @(negedge clk);
    end
    if (!done) check_eq("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int nb;
    issue_md(f, a, b);
    wait_done(nb);
    check_eq("busy_cycles", 64'(nb), 64'd32);
  endtask

  task automatic comb(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                      input string tag, input logic [31:0] exp_out, input logic exp_ovf);
    aluFunct = f; opA = a; opB = b;
    #1;
    check_eq(tag, 64'(out), 64'(exp_out));
    check_eq({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nb;
    logic [31:0] old_hi, old_lo, a, b;
    logic [32:0] s33;
    logic [5:0] f;

    reset = 1'b1; start = 1'b0; opA = '0; opB = '0; aluFunct = FUN_NO;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Combinational path
    comb(FUN_ADD,  32'h7FFF_FFFF, 32'h1,          "add_ovf",  32'h8000_0000, 1'b1);
    comb(FUN_ADDU, 32'h7FFF_FFFF, 32'h1,          "addu",     32'h8000_0000, 1'b0);
    comb(FUN_SUB,  32'h8000_0000, 32'h1,          "sub_ovf",  32'h7FFF_FFFF, 1'b1);
    comb(FUN_SUBU, 32'h8000_0000, 32'h1,          "subu",     32'h7FFF_FFFF, 1'b0);
    comb(FUN_ADD,  32'h8000_0000, 32'h8000_0000,  "add_nn",   32'h0,         1'b1);
    check_eq("zero_flag", 64'(zero), 64'd1);
    comb(FUN_SUB,  32'h5,         32'h7,          "sub_neg",  32'hFFFF_FFFE, 1'b0);
    check_eq("zero_clr", 64'(zero), 64'd0);
    comb(FUN_SRA,  32'h24,        32'h8000_0000,  "sra",      32'hF800_0000, 1'b0);
    comb(FUN_SLL,  32'h4,         32'h1,          "sll",      32'h10,        1'b0);
    comb(FUN_SRLV, 32'h21,        32'h8000_0000,  "srlv",     32'h4000_0000, 1'b0);
    comb(FUN_LUI,  32'h0,         32'h0000_ABCD,  "lui",      32'hABCD_0000, 1'b0);
    comb(FUN_SLT,  32'hFFFF_FFFF, 32'h1,          "slt",      32'h1,         1'b0);
    comb(FUN_SLTU, 32'hFFFF_FFFF, 32'h1,          "sltu",     32'h0,         1'b0);
    comb(FUN_SLE,  32'h5,         32'h5,          "sle",      32'h1,         1'b0);
    comb(FUN_NOR,  32'hF0F0_0000, 32'h0000_0F0F,  "nor",      32'h0F0F_F0F0, 1'b0);
    comb(FUN_JR,   32'h1234,      32'h5678,       "jr",       32'h0,         1'b0);
    comb(6'h3E,    32'h1234,      32'h5678,       "undef",    32'h0,         1'b0);
    @(negedge clk);

    // Multiply / divide directed cases
    run_md(FUN_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    check_eq("done_single_pulse", 64'(done), 64'd0);
    run_md(FUN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    comb(FUN_MFHI, 32'h0, 32'h0, "mfhi", 32'hFFFF_FFFE, 1'b0);
    comb(FUN_MFLO, 32'h0, 32'h0, "mflo", 32'h0000_0001, 1'b0);
    @(negedge clk);
    run_md(FUN_DIV,  32'hFFFF_FFF9, 32'h2);
    @(negedge clk);
    run_md(FUN_DIVU, 32'h7,         32'h0);
    @(negedge clk);
    run_md(FUN_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
    // Back-to-back issue in the DONE cycle
    issue_md(FUN_MULT, 32'hFFFF_FFFD, 32'h5);
    wait_done(nb);
    check_eq("b2b_busy_cycles", 64'(nb), 64'd32);
    @(negedge clk);

    // Starts during RUN are ignored; MFLO shows the pre-operation value
    old_hi = hi; old_lo = lo;
    issue_md(FUN_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    drive_start(FUN_DIV, 32'd100, 32'd7);
    drive_start(FUN_MTHI, 32'hDEAD_BEEF, 32'h0);
    check_eq("run_hi_hold", 64'(hi), 64'(old_hi));
    aluFunct = FUN_MFLO;
    #1;
    check_eq("run_mflo_old", 64'(out), 64'(old_lo));
    aluFunct = FUN_NO;
    wait_done(nb);
    check_eq("run_rest_cycles", 64'(nb), 64'd30);
    @(negedge clk);

    // Async reset aborts a running operation
    issue_md(FUN_MULT, 32'h5, 32'h6);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_hilo", {hi, lo}, 64'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("abort_no_done", 64'(done), 64'd0);
    end
    drive_start(FUN_MTLO, 32'd1234, 32'h0);
    check_eq("mtlo", 64'(lo), 64'd1234);
    check_eq("mtlo_hi", 64'(hi), 64'd0);
    check_eq("mtlo_no_done", 64'(done), 64'd0);
    drive_start(FUN_MTHI, 32'hCAFE_F00D, 32'h0);
    check_eq("mthi", 64'(hi), 64'hCAFE_F00D);

    // Random sweep
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0: f = FUN_MULT;
        1: f = FUN_MULTU;
        2: f = FUN_DIV;
        default: f = FUN_DIVU;
      endcase
      run_md(f, rnd_op(), rnd_op());
      @(negedge clk);
    end
    for (int i = 0; i < 200; i++) begin
      a = rnd_op(); b = rnd_op();
      if (i % 2 == 0) begin
        s33 = {a[31], a} + {b[31], b};
        comb(FUN_ADD, a, b, "rnd_add", s33[31:0], s33[32] != s33[31]);
      end else begin
        s33 = {a[31], a} - {b[31], b};
        comb(FUN_SUB, a, b, "rnd_sub", s33[31:0], s33[32] != s33[31]);
      end
    end
    @(negedge clk);
    check_eq("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
